// File: rtl/aidc_lite_cfg_apb_slv.sv
// APB configuration slave for the AIDC-lite engine: SRC/DST/LEN/CTRL/STATUS registers,
// start/done handshake and optional wait states. Optional IRQ support: AIDC_LITE_CFG_IRQ_EN.
module aidc_lite_cfg_apb_slv #(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        psel,
    input  logic        penable,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr,
    output logic [31:0] cfg_src_addr,
    output logic [31:0] cfg_dst_addr,
    output logic [31:0] cfg_len,
    output logic        start_o,
    input  logic        done_i
`ifdef AIDC_LITE_CFG_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic {StIdle, StAccess} state_t;

    localparam logic [3:0] WaitMax = 4'(WAIT_CYCLES);

    state_t      r_state;
    logic [3:0]  r_wait_cnt;
    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [31:0] r_len;
    logic        r_busy;
    logic        r_done;
    logic        r_start;
`ifdef AIDC_LITE_CFG_IRQ_EN
    logic        r_irq_en;
`endif

    logic        w_ready;
    logic        w_sel_src;
    logic        w_sel_dst;
    logic        w_sel_len;
    logic        w_sel_ctrl;
    logic        w_sel_status;
    logic        w_sel_irq_en;
    logic        w_mapped;
    logic        w_err;
    logic        w_commit;
    logic        w_start;
    logic        w_clr_done;
    logic [31:0] w_rdata;

    // Full-address compare: misaligned addresses never match, so they fall out as unmapped.
    always_comb begin
        w_sel_src    = (paddr == 32'h0000_0000);
        w_sel_dst    = (paddr == 32'h0000_0004);
        w_sel_len    = (paddr == 32'h0000_0008);
        w_sel_ctrl   = (paddr == 32'h0000_000C);
        w_sel_status = (paddr == 32'h0000_0010);
`ifdef AIDC_LITE_CFG_IRQ_EN
        w_sel_irq_en = (paddr == 32'h0000_0014);
`else
        w_sel_irq_en = 1'b0;
`endif
        w_mapped = w_sel_src | w_sel_dst | w_sel_len | w_sel_ctrl | w_sel_status | w_sel_irq_en;
    end

    always_comb begin
        w_err = 1'b0;
        if (!w_mapped) begin
            w_err = 1'b1;
        end else if (pwrite) begin
            if ((w_sel_src | w_sel_dst | w_sel_len) && r_busy) w_err = 1'b1;
            if (w_sel_ctrl && pwdata[0] && (r_busy || (r_len == 32'd0))) w_err = 1'b1;
`ifndef AIDC_LITE_CFG_IRQ_EN
            if (w_sel_status) w_err = 1'b1;
`endif
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        if (w_sel_src)    w_rdata = r_src;
        if (w_sel_dst)    w_rdata = r_dst;
        if (w_sel_len)    w_rdata = r_len;
        if (w_sel_ctrl)   w_rdata = {31'd0, r_busy};
        if (w_sel_status) w_rdata = {31'd0, r_done};
`ifdef AIDC_LITE_CFG_IRQ_EN
        if (w_sel_irq_en) w_rdata = {31'd0, r_irq_en};
`endif
    end

    always_comb begin
        w_ready    = !rst && (r_state == StAccess) && psel && penable && (r_wait_cnt == WaitMax);
        w_commit   = w_ready && pwrite && !w_err;
        w_start    = w_commit && w_sel_ctrl && pwdata[0];
`ifdef AIDC_LITE_CFG_IRQ_EN
        w_clr_done = w_commit && w_sel_status && pwdata[0];
`else
        w_clr_done = 1'b0;
`endif
        pready  = w_ready;
        pslverr = w_ready && w_err;
        prdata  = (w_ready && !pwrite && !w_err) ? w_rdata : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_wait_cnt <= 4'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_wait_cnt <= 4'd0;
                    if (psel && !penable) r_state <= StAccess;
                end
                StAccess: begin
                    if (!psel) begin
                        r_state    <= StIdle;
                        r_wait_cnt <= 4'd0;
                    end else if (penable) begin
                        if (r_wait_cnt == WaitMax) begin
                            r_state    <= StIdle;
                            r_wait_cnt <= 4'd0;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 4'd1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src   <= 32'd0;
            r_dst   <= 32'd0;
            r_len   <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_start <= 1'b0;
`ifdef AIDC_LITE_CFG_IRQ_EN
            r_irq_en <= 1'b0;
`endif
        end else begin
            r_start <= w_start;
            if (w_commit && w_sel_src) r_src <= pwdata;
            if (w_commit && w_sel_dst) r_dst <= pwdata;
            if (w_commit && w_sel_len) r_len <= pwdata;
`ifdef AIDC_LITE_CFG_IRQ_EN
            if (w_commit && w_sel_irq_en) r_irq_en <= pwdata[0];
`endif
            // An accepted start implies busy was 0, so done_i cannot collide with it.
            if (w_start) begin
                r_busy <= 1'b1;
                r_done <= 1'b0;
            end else begin
                if (w_clr_done) r_done <= 1'b0;
                if (done_i && r_busy) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign cfg_src_addr = r_src;
    assign cfg_dst_addr = r_dst;
    assign cfg_len      = r_len;
    assign start_o      = r_start && !rst;
`ifdef AIDC_LITE_CFG_IRQ_EN
    assign irq          = r_done & r_irq_en;
`endif

endmodule
